// File: rtl/frame_buf_pkg.sv
// rtl/frame_buf_pkg.sv - shared defaults, state encoding and address helper for the frame write scheduler
package frame_buf_pkg;

    localparam int          BURST_LEN_DEF    = 16;
    localparam int          FIFO_DEPTH_DEF   = 64;
    localparam int          FRAME_PIXELS_DEF = 76800;
    localparam logic [31:0] BASE0_DEF        = 32'h1000_0000;
    localparam logic [31:0] BASE1_DEF        = 32'h1002_5800;
    localparam int          BYTES_PER_PIXEL  = 2;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_FILL = 2'd1,
        ST_REQ  = 2'd2,
        ST_XFER = 2'd3
    } fws_state_e;

    function automatic logic [31:0] buf_base(input logic sel, input logic [31:0] b0, input logic [31:0] b1);
        return sel ? b1 : b0;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous first-word-fall-through pixel FIFO with count and flush
module pixel_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: a push into a full FIFO is lost, a pop from an empty one does nothing; flush wins.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/frame_write_sched.sv
// rtl/frame_write_sched.sv - double-buffered frame write burst scheduler (FWS_STATS_EN adds frame_cnt/drop_cnt)
module frame_write_sched
    import frame_buf_pkg::*;
#(
    parameter int          BURST_LEN    = BURST_LEN_DEF,
    parameter int          FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int          FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter logic [31:0] BASE0        = BASE0_DEF,
    parameter logic [31:0] BASE1        = BASE1_DEF
) (
    input  logic        p_clock,
    input  logic        rst,
    input  logic [15:0] pixel_data,
    input  logic        pixel_valid,
    input  logic        frame_done,
    output logic        burst_req,
    output logic [31:0] burst_addr,
    input  logic        burst_ack,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        buf_sel,
    output logic [31:0] disp_base,
    output logic        frame_drop,
    output logic        overflow
`ifdef FWS_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          PCW         = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]  BURST_CNT = CW'(BURST_LEN);
    localparam logic [PCW-1:0] POP_LAST  = PCW'(BURST_LEN - 1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * BYTES_PER_PIXEL);
    localparam logic [31:0] FRAME_BYTES = 32'(FRAME_PIXELS * BYTES_PER_PIXEL);
    localparam logic [31:0] FRAME_PIX_C = 32'(FRAME_PIXELS);

    fws_state_e     state_q, state_d;
    logic           fd_q, fd_d;
    logic [31:0]    offset_q, offset_d;
    logic [PCW-1:0] pop_cnt_q, pop_cnt_d;
    logic           pend_q, pend_d;
    logic           bad_q, bad_d;
    logic [31:0]    pix_cnt_q, pix_cnt_d;
    logic           buf_sel_q, buf_sel_d;
    logic [31:0]    disp_base_q, disp_base_d;
    logic           burst_req_q, burst_req_d;
    logic [31:0]    burst_addr_q, burst_addr_d;
    logic           frame_drop_q, frame_drop_d;
    logic           overflow_q, overflow_d;
`ifdef FWS_STATS_EN
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
`endif

    logic          fd_rise, fd_fall;
    logic          pix_in, pop_eff, burst_done, boundary;
    logic          fifo_push, pix_drop;
    logic [31:0]   off_inc;
    logic          burst_fits;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    assign fd_rise    = frame_done && !fd_q;
    assign fd_fall    = !frame_done && fd_q;
    assign pix_in     = pixel_valid && (state_q != ST_SYNC);
    assign pop_eff    = rd_en && (state_q == ST_XFER) && !fifo_empty;
    assign burst_done = pop_eff && (pop_cnt_q == POP_LAST);
    assign boundary   = ((state_q == ST_FILL) && fd_rise) || (burst_done && (pend_q || fd_rise));
    assign fifo_push  = pix_in && !boundary;
    assign pix_drop   = fifo_push && fifo_full;
    assign off_inc    = offset_q + BURST_BYTES;
    assign burst_fits = (off_inc <= FRAME_BYTES);

    pixel_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (p_clock),
        .rst       (rst),
        .flush     (boundary),
        .push      (fifo_push),
        .push_data (pixel_data),
        .pop       (pop_eff),
        .head      (rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Scheduler next-state: burst sequencing, deferred frame boundaries and buffer swap decision.
    always_comb begin
        state_d      = state_q;
        fd_d         = frame_done;
        offset_d     = offset_q;
        pop_cnt_d    = pop_cnt_q;
        pend_d       = pend_q;
        bad_d        = bad_q;
        pix_cnt_d    = pix_cnt_q;
        buf_sel_d    = buf_sel_q;
        disp_base_d  = disp_base_q;
        burst_req_d  = burst_req_q;
        burst_addr_d = burst_addr_q;
        frame_drop_d = 1'b0;
        overflow_d   = overflow_q;
`ifdef FWS_STATS_EN
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
`endif

        if (fifo_push) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
        end
        if (pix_drop) begin
            overflow_d = 1'b1;
            bad_d      = 1'b1;
        end

        case (state_q)
            ST_SYNC: begin
                if (fd_fall) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // A burst past the end of the frame is never requested; its pixels wait for the flush.
                if (!fd_rise && (fifo_count >= BURST_CNT) && burst_fits) begin
                    state_d      = ST_REQ;
                    burst_req_d  = 1'b1;
                    burst_addr_d = buf_base(buf_sel_q, BASE0, BASE1) + offset_q;
                end
            end
            ST_REQ: begin
                if (fd_rise) begin
                    pend_d = 1'b1;
                end
                if (burst_ack) begin
                    state_d     = ST_XFER;
                    burst_req_d = 1'b0;
                end
            end
            ST_XFER: begin
                if (fd_rise) begin
                    pend_d = 1'b1;
                end
                if (pop_eff) begin
                    pop_cnt_d = pop_cnt_q + 1'b1;
                end
                if (burst_done) begin
                    pop_cnt_d = '0;
                    offset_d  = burst_fits ? off_inc : FRAME_BYTES;
                    state_d   = ST_FILL;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // Frame boundary: flush leftovers, restart the frame, publish or drop the finished one.
        if (boundary) begin
            state_d   = ST_FILL;
            offset_d  = '0;
            pop_cnt_d = '0;
            pend_d    = 1'b0;
            pix_cnt_d = '0;
            bad_d     = 1'b0;
            if ((pix_cnt_q == FRAME_PIX_C) && !bad_q) begin
                disp_base_d = buf_base(buf_sel_q, BASE0, BASE1);
                buf_sel_d   = !buf_sel_q;
`ifdef FWS_STATS_EN
                frame_cnt_d = frame_cnt_q + 16'd1;
`endif
            end else begin
                frame_drop_d = 1'b1;
`ifdef FWS_STATS_EN
                drop_cnt_d   = drop_cnt_q + 16'd1;
`endif
            end
        end
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge p_clock) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            fd_q         <= 1'b0;
            offset_q     <= '0;
            pop_cnt_q    <= '0;
            pend_q       <= 1'b0;
            bad_q        <= 1'b0;
            pix_cnt_q    <= '0;
            buf_sel_q    <= 1'b0;
            disp_base_q  <= BASE1;
            burst_req_q  <= 1'b0;
            burst_addr_q <= '0;
            frame_drop_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef FWS_STATS_EN
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fd_q         <= fd_d;
            offset_q     <= offset_d;
            pop_cnt_q    <= pop_cnt_d;
            pend_q       <= pend_d;
            bad_q        <= bad_d;
            pix_cnt_q    <= pix_cnt_d;
            buf_sel_q    <= buf_sel_d;
            disp_base_q  <= disp_base_d;
            burst_req_q  <= burst_req_d;
            burst_addr_q <= burst_addr_d;
            frame_drop_q <= frame_drop_d;
            overflow_q   <= overflow_d;
`ifdef FWS_STATS_EN
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    assign burst_req  = burst_req_q;
    assign burst_addr = burst_addr_q;
    assign buf_sel    = buf_sel_q;
    assign disp_base  = disp_base_q;
    assign frame_drop = frame_drop_q;
    assign overflow   = overflow_q;
`ifdef FWS_STATS_EN
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: doc/frame_write_sched.md
FRAME_WRITE_SCHED -- requirements
Module: frame_write_sched

Interface
REQ-001 The module SHALL have these parameters: BURST_LEN, default 16, pixels per write burst; FIFO_DEPTH, default 64, pixel FIFO entries (power of two, at least 2*BURST_LEN); FRAME_PIXELS, default 76800, pixels per 320x240 frame; BASE0, default 32'h1000_0000, byte base address of frame buffer 0; BASE1, default 32'h1002_5800, byte base address of frame buffer 1.
REQ-002 p_clock  in  1  sole clock; all logic SHALL be rising-edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 pixel_data  in  16  captured pixel.
REQ-005 pixel_valid  in  1  one-cycle qualifier for pixel_data.
REQ-006 frame_done  in  1  level, high for the whole vsync interval.
REQ-007 burst_req  out  1  burst request to the AXI writer.
REQ-008 burst_addr  out  32  byte address of the requested burst; stable while burst_req=1.
REQ-009 burst_ack  in  1  writer accepts the burst.
REQ-010 rd_en  in  1  writer pops one FIFO word.
REQ-011 rd_data  out  16  FIFO head, first-word-fall-through.
REQ-012 buf_sel  out  1  buffer currently being written.
REQ-013 disp_base  out  32  base address of the last complete frame.
REQ-014 frame_drop  out  1  one-cycle pulse when a frame is abandoned.
REQ-015 overflow  out  1  sticky flag set when a pixel is lost.

Function
REQ-016 The FSM SHALL have states SYNC, FILL, REQ and XFER.
REQ-017 SYNC SHALL discard pixels and SHALL exit to FILL on the first frame_done falling edge after reset.
REQ-018 In FILL, pixels SHALL be pushed into the FIFO; when the count reaches BURST_LEN or more, the FSM SHALL enter REQ on the next cycle.
REQ-019 In REQ, burst_req SHALL be 1 and burst_addr SHALL equal the base of buf_sel plus offset; on burst_ack, the FSM SHALL go to XFER and burst_req SHALL drop on the following cycle.
REQ-020 In XFER, the block SHALL count rd_en pops; after BURST_LEN pops, offset SHALL increase by BURST_LEN*2 and the FSM SHALL return to FILL.
REQ-021 rd_en while the FIFO is empty, or outside XFER, SHALL be ignored and SHALL NOT be counted.
REQ-022 Pixel writes SHALL continue in every state except SYNC; a push with the FIFO full SHALL drop the pixel, set overflow and mark the current frame bad.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged.
REQ-024 A frame boundary is the rising edge of frame_done; in FILL it SHALL be handled immediately, and in REQ or XFER it SHALL be deferred (pending flag) until the burst completes.
REQ-025 At a boundary, the FIFO SHALL be flushed, the residual partial burst discarded and offset cleared.
REQ-026 If the frame wrote exactly FRAME_PIXELS pixels and is not bad, disp_base SHALL take the old buffer base and buf_sel SHALL toggle; otherwise frame_drop SHALL pulse, buf_sel SHALL be held and the frame bad mark cleared.
REQ-027 offset SHALL saturate at FRAME_PIXELS*2; a burst that would exceed it SHALL NOT be requested, and its pixels SHALL be dropped at the next boundary.

Reset
REQ-028 On rst, the state SHALL be SYNC and all of the following SHALL be 0: burst_req, burst_addr, buf_sel, frame_drop, overflow, FIFO contents and count, offset, pop count, pending and bad flags.
REQ-029 On rst, disp_base SHALL be BASE1, and rd_data SHALL be 0.
REQ-030 rst SHALL abort any request or transfer immediately; the writer SHALL tolerate the withdrawn burst_req.

Configuration
REQ-031 With FWS_STATS_EN defined, the block SHALL add outputs frame_cnt[15:0], counting completed frames, and drop_cnt[15:0], counting frame_drop pulses; both SHALL wrap, be cleared by rst and update on the boundary cycle.
REQ-032 Without FWS_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 The parameter defaults, the FSM state encoding and the bytes-per-pixel constant (2) SHALL reside in shared package frame_buf_pkg.
REQ-034 The FIFO SHALL be the sub-module pixel_fifo: synchronous, first-word-fall-through, with count and flush ports.

Verification
REQ-035 Reset, then frame_done 1->0, then 16 pixels -> burst_req=1 with burst_addr=32'h1000_0000; ack then 16 pops -> next burst_addr=32'h1000_0020.
REQ-036 Full frame of 76800 pixels with prompt acks, then frame_done rising -> buf_sel=1, disp_base=32'h1000_0000, next burst_addr=32'h1002_5800.
REQ-037 Writer stalls (no ack) while 70 pixels are pushed with FIFO_DEPTH=64 -> overflow=1, and at the boundary frame_drop pulses for one cycle with buf_sel unchanged.
REQ-038 frame_done rises mid-XFER after 5 of 16 pops -> the transfer completes all 16 pops, then flush; offset=0 and the 7 residual pixels are discarded.
REQ-039 Push and pop on the same cycle at count 16 -> count stays 16 and rd_data advances in order.
REQ-040 rst asserted in REQ -> burst_req=0 on the next cycle, state SYNC, and pixels are ignored until a frame_done falling edge.
